// File: rtl/pc_branch_unit.sv
// PC register, NZCV status register and branch-target arithmetic
// for the multicycle LEGv8 datapath; resolves B.cond from stored flags.
module pc_branch_unit #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [1:0]      PC_FS,
    input  logic [2:0]      k_mux,
    input  logic [31:0]     IR,
    input  logic [PC_W-1:0] pc_in,
    input  logic [3:0]      status_in,
    input  logic            status_load,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] k_out,
    output logic [3:0]      status,
    output logic            cond_true,
    output logic            branch_taken,
    output logic            pc_fault
);

    localparam logic [PC_W-1:0] FOUR = PC_W'(4);

    localparam logic [1:0] FS_HOLD = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_JUMP = 2'b11;

    logic            flag_v;
    logic            flag_c;
    logic            flag_n;
    logic            flag_z;
    logic            is_bcond;
    logic            jump_taken;
    logic            misaligned;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_next;

    assign flag_v = status[3];
    assign flag_c = status[2];
    assign flag_n = status[1];
    assign flag_z = status[0];

    assign pc_plus4 = PC + FOUR;
    assign target   = PC + {k_out[PC_W-3:0], 2'b00};

    assign is_bcond   = (IR[31:24] == 8'h54) && (k_mux == 3'b011);
    assign jump_taken = (PC_FS == FS_JUMP) && (!is_bcond || cond_true);
    assign misaligned = (PC_FS == FS_LOAD) && (pc_in[1:0] != 2'b00);

    // Sign-extend the immediate field chosen by k_mux.
    always_comb begin
        k_out = '0;
        case (k_mux)
            3'b010:  k_out = {{(PC_W-26){IR[25]}}, IR[25:0]};
            3'b011:  k_out = {{(PC_W-19){IR[23]}}, IR[23:5]};
            default: k_out = '0;
        endcase
    end

    // Evaluate the IR[3:0] condition against the registered flags.
    always_comb begin
        cond_true = 1'b1;
        case (IR[3:0])
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = ~flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = ~flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = ~flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = ~flag_v;
            4'h8:    cond_true = flag_c & ~flag_z;
            4'h9:    cond_true = ~(flag_c & ~flag_z);
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = ~flag_z & (flag_n == flag_v);
            4'hD:    cond_true = ~(~flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    // Select the next PC; a failed B.cond falls through to PC+4.
    always_comb begin
        pc_next = PC;
        case (PC_FS)
            FS_HOLD: pc_next = PC;
            FS_INC:  pc_next = pc_plus4;
            FS_LOAD: pc_next = {pc_in[PC_W-1:2], 2'b00};
            FS_JUMP: pc_next = jump_taken ? target : pc_plus4;
            default: pc_next = PC;
        endcase
    end

    // PC, flags, taken pulse and sticky fault registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            PC           <= RESET_PC;
            status       <= 4'b0000;
            branch_taken <= 1'b0;
            pc_fault     <= 1'b0;
        end else begin
            PC           <= pc_next;
            branch_taken <= (PC_FS == FS_LOAD) || jump_taken;
            pc_fault     <= pc_fault | misaligned;
            if (status_load) begin
                status <= status_in;
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: vector table through a
// scoreboard queue, plus reset, immediate and condition-code sequences.
module tb_pc_branch_unit;

    logic        clock;
    logic        reset_n;
    logic [1:0]  PC_FS;
    logic [2:0]  k_mux;
    logic [31:0] IR;
    logic [63:0] pc_in;
    logic [3:0]  status_in;
    logic        status_load;
    logic [63:0] PC;
    logic [63:0] pc_plus4;
    logic [63:0] k_out;
    logic [3:0]  status;
    logic        cond_true;
    logic        branch_taken;
    logic        pc_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  fs;
        logic [2:0]  km;
        logic [31:0] ir;
        logic [63:0] pin;
        logic [3:0]  sin;
        logic        sl;
        logic [63:0] exp_pc;
        logic        exp_bt;
        logic [3:0]  exp_st;
        logic        exp_flt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pc_branch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .PC_FS        (PC_FS),
        .k_mux        (k_mux),
        .IR           (IR),
        .pc_in        (pc_in),
        .status_in    (status_in),
        .status_load  (status_load),
        .PC           (PC),
        .pc_plus4     (pc_plus4),
        .k_out        (k_out),
        .status       (status),
        .cond_true    (cond_true),
        .branch_taken (branch_taken),
        .pc_fault     (pc_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] s,
                                        input logic [3:0] code);
        logic v, c, n, z, base;
        v = s[3]; c = s[2]; n = s[1]; z = s[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (code[0] && code != 4'hF) return !base;
        return base;
    endfunction

    function automatic vec_t mk(input logic [1:0] fs, input logic [2:0] km,
                                input logic [31:0] ir, input logic [63:0] pin,
                                input logic [3:0] sin, input logic sl,
                                input logic [63:0] epc, input logic ebt,
                                input logic [3:0] est, input logic eflt);
        vec_t v;
        v.fs = fs; v.km = km; v.ir = ir; v.pin = pin;
        v.sin = sin; v.sl = sl; v.exp_pc = epc; v.exp_bt = ebt;
        v.exp_st = est; v.exp_flt = eflt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        PC_FS = v.fs; k_mux = v.km; IR = v.ir; pc_in = v.pin;
        status_in = v.sin; status_load = v.sl;
    endtask

    task automatic idle();
        PC_FS = 2'b00; k_mux = 3'b000; IR = 32'h0;
        pc_in = 64'h0; status_in = 4'h0; status_load = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t e;
        reset_n = 1'b0;
        idle();

        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'h4, 0, 4'h0, 0));
        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'h8, 0, 4'h0, 0));
        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'hC, 0, 4'h0, 0));
        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'h10, 0, 4'h0, 0));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h100, 4'h0, 0, 64'h100, 1, 4'h0, 0));
        vecs.push_back(mk(2'b11, 3'b010, 32'h17FFFFFC, 64'h0, 4'h0, 0, 64'hF0, 1, 4'h0, 0));
        vecs.push_back(mk(2'b00, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'hF0, 0, 4'h0, 0));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h40, 4'h0, 0, 64'h40, 1, 4'h0, 0));
        vecs.push_back(mk(2'b00, 3'b000, 32'h0, 64'h0, 4'h1, 1, 64'h40, 0, 4'h1, 0));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54000020, 64'h0, 4'h0, 0, 64'h44, 1, 4'h1, 0));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h40, 4'h0, 0, 64'h40, 1, 4'h1, 0));
        vecs.push_back(mk(2'b00, 3'b000, 32'h0, 64'h0, 4'h0, 1, 64'h40, 0, 4'h0, 0));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54000020, 64'h0, 4'h0, 0, 64'h44, 0, 4'h0, 0));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h40, 4'h0, 0, 64'h40, 1, 4'h0, 0));
        vecs.push_back(mk(2'b00, 3'b000, 32'h0, 64'h0, 4'h1, 1, 64'h40, 0, 4'h1, 0));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54000040, 64'h0, 4'h0, 0, 64'h48, 1, 4'h1, 0));
        vecs.push_back(mk(2'b00, 3'b000, 32'h0, 64'h0, 4'h0, 1, 64'h48, 0, 4'h0, 0));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54000040, 64'h0, 4'h1, 1, 64'h4C, 0, 4'h1, 0));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54000040, 64'h0, 4'h0, 0, 64'h54, 1, 4'h1, 0));
        vecs.push_back(mk(2'b11, 3'b000, 32'h17FFFFFC, 64'h0, 4'h0, 0, 64'h54, 1, 4'h1, 0));
        vecs.push_back(mk(2'b11, 3'b010, 32'h54000041, 64'h0, 4'h0, 0, 64'h158, 1, 4'h1, 0));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h1003, 4'h0, 0, 64'h1000, 1, 4'h1, 1));
        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'h1004, 0, 4'h1, 1));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'h2000, 4'h0, 0, 64'h2000, 1, 4'h1, 1));
        vecs.push_back(mk(2'b10, 3'b000, 32'h0, 64'hFFFFFFFFFFFFFFFC, 4'h0, 0,
                          64'hFFFFFFFFFFFFFFFC, 1, 4'h1, 1));
        vecs.push_back(mk(2'b01, 3'b000, 32'h0, 64'h0, 4'h0, 0, 64'h0, 0, 4'h1, 1));
        vecs.push_back(mk(2'b11, 3'b010, 32'h17FFFFFC, 64'h0, 4'h0, 0,
                          64'hFFFFFFFFFFFFFFF0, 1, 4'h1, 1));
        vecs.push_back(mk(2'b11, 3'b011, 32'h54FFFFEE, 64'h0, 4'h0, 0,
                          64'hFFFFFFFFFFFFFFEC, 1, 4'h1, 1));

        #2;
        chk("reset_pc", PC, 64'h0);
        chk("reset_status", {60'h0, status}, 64'h0);
        chk("reset_bt", {63'h0, branch_taken}, 64'h0);
        chk("reset_fault", {63'h0, pc_fault}, 64'h0);

        @(posedge clock);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_pc", i), PC, e.exp_pc);
            chk($sformatf("v%0d_bt", i), {63'h0, branch_taken}, {63'h0, e.exp_bt});
            chk($sformatf("v%0d_st", i), {60'h0, status}, {60'h0, e.exp_st});
            chk($sformatf("v%0d_flt", i), {63'h0, pc_fault}, {63'h0, e.exp_flt});
            chk($sformatf("v%0d_p4", i), pc_plus4, e.exp_pc + 64'd4);
        end

        idle();
        k_mux = 3'b010; IR = 32'h17FFFFFC;
        #1 chk("k_imm26_neg", k_out, 64'hFFFFFFFFFFFFFFFC);
        k_mux = 3'b011; IR = 32'h54FFFFEE;
        #1 chk("k_imm19_neg", k_out, 64'hFFFFFFFFFFFFFFFF);
        IR = 32'h54000040;
        #1 chk("k_imm19_pos", k_out, 64'h2);
        k_mux = 3'b001;
        #1 chk("k_other", k_out, 64'h0);
        idle();

        PC_FS = 2'b10; pc_in = 64'h200;
        tick();
        idle();
        chk("pre_areset_pc", PC, 64'h200);
        #3 reset_n = 1'b0;
        #1;
        chk("areset_pc", PC, 64'h0);
        chk("areset_status", {60'h0, status}, 64'h0);
        chk("areset_fault", {63'h0, pc_fault}, 64'h0);
        chk("areset_bt", {63'h0, branch_taken}, 64'h0);
        PC_FS = 2'b01;
        tick();
        chk("hold_in_reset", PC, 64'h0);
        reset_n = 1'b1;
        tick();
        chk("first_after_release", PC, 64'h4);
        idle();

        for (int s = 0; s < 16; s++) begin
            status_in = 4'(s);
            status_load = 1'b1;
            tick();
            status_load = 1'b0;
            chk($sformatf("st_load_%0d", s), {60'h0, status}, 64'(s));
            for (int c = 0; c < 16; c++) begin
                IR = {28'h5400000, 4'(c)};
                #1;
                chk($sformatf("cond_s%0d_c%0d", s, c), {63'h0, cond_true},
                    {63'h0, cond_model(4'(s), 4'(c))});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
